// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage sitting directly upstream of the IF/ID register.
//
// Owns the program counter. Keeps at most one request outstanding to instruction
// memory using a level handshake. Presents {pc, instr} with a valid flag to IF/ID.
// When downstream stalls, a one-entry skid buffer absorbs the instruction that was
// already in flight. A redirect squashes both in-flight and buffered instructions.
//
// Parameters
//   XLEN      PC / address width; o_ifid is XLEN+32 bits wide
//   RESET_PC  first PC fetched after reset (word aligned)
//
// Ports
//   clk, reset     clock and synchronous active-high reset
//   o_imem_req     request to instruction memory, held until i_imem_ack
//   o_imem_addr    word address of the request, stable while o_imem_req is high
//   i_imem_ack     one-cycle acknowledge carrying i_imem_rdata
//   i_imem_rdata   fetched instruction, valid only with i_imem_ack
//   i_stall        downstream is not accepting (IF/ID enable = ~i_stall)
//   i_redirect     one-cycle pulse: squash and refetch from i_redirect_pc
//   i_redirect_pc  redirect target; the low two bits are ignored
//   o_valid        o_ifid holds a live instruction
//   o_ifid         {pc, instr}
//
// Optional feature: define FETCH_PERF_CNT_EN to add two saturating counters.
//   o_stall_cycles  cycles with o_valid & i_stall
//   o_fetch_count   instructions accepted downstream
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               o_imem_req,
  output logic [XLEN-1:0]    o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [31:0]        i_imem_rdata,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [XLEN-1:0]    i_redirect_pc,
  output logic               o_valid,
  output logic [XLEN+31:0]   o_ifid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        o_stall_cycles,
  output logic [31:0]        o_fetch_count
`endif
);

  // IDLE: one settling cycle after reset
  // REQ:  request live
  // DROP: squashed request still awaiting its ack
  // HOLD: skid buffer full, no request
  typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic              valid_q, valid_d;
  logic [XLEN+31:0]  ifid_q, ifid_d;
  logic [XLEN+31:0]  skid_q, skid_d;

  logic              consume;
  logic              slot_free;
  logic [XLEN-1:0]   redirect_pc;
  logic [XLEN-1:0]   pc_plus4;
  logic              unused_redirect_lsbs;

  assign consume              = valid_q & ~i_stall;
  assign slot_free            = ~valid_q | consume;
  assign redirect_pc          = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign pc_plus4             = pc_q + XLEN'(4);
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      valid_q    <= 1'b0;
      ifid_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      valid_q    <= valid_d;
      ifid_q     <= ifid_d;
      skid_q     <= skid_d;
    end
  end

  // Next-state and datapath. Two rules are applied outside the state case:
  // a consumed instruction leaves the slot, and a redirect clears the slot last.
  // Applying the redirect last lets it override both consume and stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    valid_d    = valid_q;
    ifid_d     = ifid_q;
    skid_d     = skid_q;

    if (consume) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (i_redirect) begin
          pc_d       = redirect_pc;
          req_addr_d = redirect_pc;
        end else begin
          req_addr_d = pc_q;
        end
      end

      REQ: begin
        if (i_imem_ack) begin
          if (i_redirect) begin
            // The returned data belongs to the squashed path.
            pc_d       = redirect_pc;
            req_addr_d = redirect_pc;
          end else if (slot_free) begin
            ifid_d     = {req_addr_q, i_imem_rdata};
            valid_d    = 1'b1;
            pc_d       = pc_plus4;
            req_addr_d = pc_plus4;
          end else begin
            skid_d  = {req_addr_q, i_imem_rdata};
            pc_d    = pc_plus4;
            state_d = HOLD;
          end
        end else if (i_redirect) begin
          // A request cannot be withdrawn, so wait out its ack in DROP.
          pc_d    = redirect_pc;
          state_d = DROP;
        end
      end

      DROP: begin
        if (i_redirect) begin
          pc_d = redirect_pc;
        end
        if (i_imem_ack) begin
          state_d    = REQ;
          req_addr_d = i_redirect ? redirect_pc : pc_q;
        end
      end

      HOLD: begin
        if (i_redirect) begin
          pc_d       = redirect_pc;
          req_addr_d = redirect_pc;
          state_d    = REQ;
        end else if (consume) begin
          ifid_d     = skid_q;
          valid_d    = 1'b1;
          req_addr_d = pc_q;
          state_d    = REQ;
        end
      end

      default: state_d = IDLE;
    endcase

    if (i_redirect) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    o_imem_req  = (state_q == REQ) || (state_q == DROP);
    o_imem_addr = req_addr_q;
    o_valid     = valid_q;
    o_ifid      = ifid_q;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  // Both counters stop at all-ones instead of wrapping.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    fetch_count_d  = fetch_count_q;
    if (valid_q && i_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (consume && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      fetch_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      fetch_count_q  <= fetch_count_d;
    end
  end

  assign o_stall_cycles = stall_cycles_q;
  assign o_fetch_count  = fetch_count_q;
`endif

endmodule
